bcd_digit_chain: RTL and testbench

- Downstream stage of the single-digit decade counter; consumes that counter's carry pulse (cout) as tick_in.
- Extends the count to DIGITS cascaded BCD digits, with clear, load and enable control.
- Provides a one-shot snapshot port with valid/ready handshake so a slower consumer reads a coherent multi-digit value.

---
 rtl/bcd_digit_chain.sv | 142 ++++++++++++++
 tb/tb_bcd_digit_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_chain.sv
// Cascaded BCD digit counter fed by an upstream decade-counter carry.
// Adds clear/load/enable control and a valid/ready snapshot port.
module bcd_digit_chain #(
    parameter  int DIGITS = 4,
    localparam int CW     = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          tick_in,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          ovf,
    output logic          load_err,
    input  logic          snap_req,
    output logic [CW-1:0] snap_data,
    output logic          snap_valid,
    input  logic          snap_ready,
    output logic          snap_miss
);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } snap_state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          load_err_q, load_err_d;
    logic [CW-1:0] snap_data_q, snap_data_d;
    logic          snap_miss_q, snap_miss_d;
    snap_state_t   state_q, state_d;

    logic [CW-1:0] inc_val;
    logic          inc_wrap;
    logic [CW-1:0] load_clean;
    logic          load_bad;

    // Ripple a +1 through the digits; carry out of the top digit is a wrap.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        inc_val = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        inc_wrap = carry;
    end

    // Replace any non-BCD load digit with 0 and flag it.
    always_comb begin
        load_clean = load_val;
        load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
                load_bad = 1'b1;
            end
        end
    end

    // Count next-state: clr > load > accepted tick > hold.
    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d      = load_clean;
            load_err_d = load_bad;
        end else if (en && tick_in) begin
            cnt_d = inc_val;
            ovf_d = inc_wrap;
        end
    end

    // Snapshot FSM; captures the pre-update count of the request cycle.
    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        snap_miss_d = snap_miss_q & ~clr;
        unique case (state_q)
            S_EMPTY: begin
                if (snap_req) begin
                    snap_data_d = cnt_q;
                    state_d     = S_FULL;
                end
            end
            S_FULL: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        snap_data_d = cnt_q;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end else if (snap_req) begin
                    snap_miss_d = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            load_err_q  <= 1'b0;
            snap_data_q <= '0;
            snap_miss_q <= 1'b0;
            state_q     <= S_EMPTY;
        end else begin
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            load_err_q  <= load_err_d;
            snap_data_q <= snap_data_d;
            snap_miss_q <= snap_miss_d;
            state_q     <= state_d;
        end
    end

    assign cnt        = cnt_q;
    assign ovf        = ovf_q;
    assign load_err   = load_err_q;
    assign snap_data  = snap_data_q;
    assign snap_valid = (state_q == S_FULL);
    assign snap_miss  = snap_miss_q;

endmodule

// File: tb/tb_bcd_digit_chain.sv
// Directed testbench for bcd_digit_chain with DIGITS=4.
// Each task drives a scenario and checks outputs a little after the edge.
module tb_bcd_digit_chain;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, en, tick_in, clr, load;
    logic [CW-1:0] load_val;
    logic [CW-1:0] cnt;
    logic          ovf, load_err;
    logic          snap_req, snap_ready;
    logic [CW-1:0] snap_data;
    logic          snap_valid, snap_miss;

    int errors = 0;
    int checks = 0;

    bcd_digit_chain #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick_in   (tick_in),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .cnt       (cnt),
        .ovf       (ovf),
        .load_err  (load_err),
        .snap_req  (snap_req),
        .snap_data (snap_data),
        .snap_valid(snap_valid),
        .snap_ready(snap_ready),
        .snap_miss (snap_miss)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; en = 0; tick_in = 0; clr = 0; load = 0;
        load_val = '0; snap_req = 0; snap_ready = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_cnt got=%h exp=0000", cnt);
        end
        checks++;
        if ({snap_valid, ovf, load_err, snap_miss} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {snap_valid, ovf, load_err, snap_miss});
        end
        checks++;
        if (snap_data !== 16'h0000) begin
            errors++; $display("FAIL reset_snap got=%h exp=0000", snap_data);
        end
    endtask

    task automatic test_increment();
        en = 1;
        for (int i = 1; i <= 12; i++) begin
            tick_in = 1;
            step();
            checks++;
            if ({ovf, snap_valid} !== 2'b00 || snap_data !== 16'h0) begin
                errors++;
                $display("FAIL inc_quiet i=%0d ovf=%b sv=%b sd=%h exp 0",
                         i, ovf, snap_valid, snap_data);
            end
            if (i == 1) begin
                checks++;
                if (cnt !== 16'h0001) begin
                    errors++; $display("FAIL inc_latency got=%h exp=0001", cnt);
                end
            end
        end
        tick_in = 0;
        step();
        checks++;
        if (cnt !== 16'h0012) begin
            errors++; $display("FAIL inc_12 got=%h exp=0012", cnt);
        end
    endtask

    task automatic test_wrap();
        load = 1; load_val = 16'h9998;
        step();
        load = 0;
        checks++;
        if (cnt !== 16'h9998) begin
            errors++; $display("FAIL wrap_load got=%h exp=9998", cnt);
        end
        en = 1; tick_in = 1;
        step();
        checks++;
        if (cnt !== 16'h9999 || ovf !== 1'b0) begin
            errors++; $display("FAIL wrap_9999 got=%h ovf=%b exp=9999/0", cnt, ovf);
        end
        step();
        checks++;
        if (cnt !== 16'h0000 || ovf !== 1'b1) begin
            errors++; $display("FAIL wrap_zero got=%h ovf=%b exp=0000/1", cnt, ovf);
        end
        tick_in = 0;
        step();
        checks++;
        if (cnt !== 16'h0000 || ovf !== 1'b0) begin
            errors++; $display("FAIL wrap_after got=%h ovf=%b exp=0000/0", cnt, ovf);
        end
    endtask

    task automatic test_priority_load();
        en = 1; tick_in = 1;
        step();
        clr = 1; load = 1; load_val = 16'h1234;
        step();
        clr = 0;
        checks++;
        if (cnt !== 16'h0000 || ovf !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr got=%h ovf=%b le=%b exp=0000/0/0",
                     cnt, ovf, load_err);
        end
        load_val = 16'h12F4;
        step();
        checks++;
        if (cnt !== 16'h1204 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL load_bad got=%h le=%b exp=1204/1", cnt, load_err);
        end
        load = 0; tick_in = 0;
        step();
        checks++;
        if (cnt !== 16'h1204 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_err_pulse got=%h le=%b exp=1204/0", cnt, load_err);
        end
        tick_in = 1; en = 0;
        step();
        tick_in = 0;
        checks++;
        if (cnt !== 16'h1204) begin
            errors++; $display("FAIL en_low got=%h exp=1204", cnt);
        end
    endtask

    task automatic test_snapshot();
        snap_ready = 1;
        step();
        snap_ready = 0;
        checks++;
        if (snap_valid !== 1'b0) begin
            errors++; $display("FAIL ready_empty sv=%b exp=0", snap_valid);
        end
        load = 1; load_val = 16'h0099;
        step();
        load = 0;
        en = 1; tick_in = 1; snap_req = 1;
        step();
        tick_in = 0; snap_req = 0;
        checks++;
        if (snap_data !== 16'h0099 || cnt !== 16'h0100 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL snap_coh sd=%h cnt=%h sv=%b exp=0099/0100/1",
                     snap_data, cnt, snap_valid);
        end
        step();
        step();
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 16'h0099) begin
            errors++;
            $display("FAIL snap_hold sv=%b sd=%h exp=1/0099", snap_valid, snap_data);
        end
    endtask

    task automatic test_back_to_back();
        snap_req = 1;
        step();
        snap_req = 0;
        checks++;
        if (snap_data !== 16'h0099 || snap_miss !== 1'b1 || snap_valid !== 1'b1) begin
            errors++;
            $display("FAIL miss sd=%h sm=%b sv=%b exp=0099/1/1",
                     snap_data, snap_miss, snap_valid);
        end
        tick_in = 1;
        step();
        tick_in = 0;
        snap_req = 1; snap_ready = 1;
        step();
        snap_req = 0;
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 16'h0101) begin
            errors++;
            $display("FAIL b2b sv=%b sd=%h exp=1/0101", snap_valid, snap_data);
        end
        step();
        snap_ready = 0;
        checks++;
        if (snap_valid !== 1'b0 || snap_miss !== 1'b1) begin
            errors++;
            $display("FAIL accept sv=%b sm=%b exp=0/1", snap_valid, snap_miss);
        end
        clr = 1;
        step();
        clr = 0;
        checks++;
        if (snap_miss !== 1'b0 || cnt !== 16'h0000 || snap_data !== 16'h0101) begin
            errors++;
            $display("FAIL clr_miss sm=%b cnt=%h sd=%h exp=0/0000/0101",
                     snap_miss, cnt, snap_data);
        end
    endtask

    task automatic test_reset_mid();
        load = 1; load_val = 16'h4321;
        step();
        load = 0; snap_req = 1;
        step();
        snap_req = 0;
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 16'h4321) begin
            errors++;
            $display("FAIL pre_rst sv=%b sd=%h exp=1/4321", snap_valid, snap_data);
        end
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (cnt !== 16'h0 || snap_valid !== 1'b0 || snap_data !== 16'h0) begin
            errors++;
            $display("FAIL mid_rst cnt=%h sv=%b sd=%h exp=0/0/0",
                     cnt, snap_valid, snap_data);
        end
        en = 0;
        for (int i = 0; i < 5; i++) begin
            tick_in = 1;
            step();
            tick_in = 0;
            step();
        end
        checks++;
        if (cnt !== 16'h0000) begin
            errors++; $display("FAIL en0_ticks got=%h exp=0000", cnt);
        end
    endtask

    initial begin
        idle();
        step();
        test_reset();
        test_increment();
        test_wrap();
        test_priority_load();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
